// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: per-bus round-robin arbiter and packet forwarder.
// Each of the `bits` buses owns an IDLE -> GRANT -> SEND controller. The
// controller pops one device's head-of-FIFO packet and pushes it to the
// destination device(s) named in the top byte of the packet.
// Optional feature: define BCAST_DELIVERY_EN so that packets addressed to the
// `broadcast` ID go to every device except the source. Without the macro that
// ID is treated like any other destination.
module bs_gnrtr_n_rbtr #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int               IW       = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [IW:0]      DRV_W    = (IW+1)'(drvrs);
    localparam logic [8:0]       DRV_9    = 9'(drvrs);
    localparam logic [IW-1:0]    LAST_IDX = IW'(drvrs - 1);
    localparam logic [drvrs-1:0] ONE_HOT0 = drvrs'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SEND
    } state_t;

    // First requester at or after `start`, wrapping past the last device.
    // Scanning from the far end lets the nearest requester overwrite the pick.
    function automatic logic [IW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                              input logic [IW-1:0]    start);
        logic [IW-1:0] pick;
        logic [IW:0]   idx;
        pick = start;
        for (int k = drvrs - 1; k >= 0; k--) begin
            idx = {1'b0, start} + (IW+1)'(k);
            if (idx >= DRV_W) begin
                idx = idx - DRV_W;
            end
            if (req[idx[IW-1:0]]) begin
                pick = idx[IW-1:0];
            end
        end
        return pick;
    endfunction

    // Receiver lanes for a packet: one lane for a valid unicast ID, none for
    // an out-of-range ID, and all-but-source for broadcast when enabled.
    function automatic logic [drvrs-1:0] dest_mask(input logic [7:0]    dst,
                                                   input logic [IW-1:0] src);
        logic [drvrs-1:0] m;
        logic [drvrs-1:0] bc_m;
        logic             is_bc;
        m     = '0;
        bc_m  = ~(ONE_HOT0 << src);
        is_bc = 1'b0;
`ifdef BCAST_DELIVERY_EN
        is_bc = (dst == broadcast);
`endif
        if (is_bc) begin
            m = bc_m;
        end else if ({1'b0, dst} < DRV_9) begin
            m[dst[IW-1:0]] = 1'b1;
        end
        return m;
    endfunction

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t             state_q;
        logic [IW-1:0]      sel_q;
        logic [IW-1:0]      rr_q;
        logic [pckg_sz-1:0] pkt_q;
        logic [pckg_sz-1:0] dpush_q;
        logic [drvrs-1:0]   pop_q;
        logic [drvrs-1:0]   push_q;
        logic [IW-1:0]      pick_d;
        logic [IW-1:0]      rr_d;
        logic [drvrs-1:0]   mask_d;

        // Arbitration choice, next search start and destination lanes.
        always_comb begin
            pick_d = rr_pick(pndng[b], rr_q);
            rr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + IW'(1);
            mask_d = dest_mask(pkt_q[pckg_sz-1 -: 8], sel_q);
        end

        // Bus controller: grant selection, pop/capture, push/deliver.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_IDLE;
                sel_q   <= '0;
                rr_q    <= '0;
                pkt_q   <= '0;
                dpush_q <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        pop_q  <= '0;
                        push_q <= '0;
                        if (|pndng[b]) begin
                            sel_q   <= pick_d;
                            state_q <= S_GRANT;
                        end
                    end
                    S_GRANT: begin
                        // The device sees pop while its head packet is captured here.
                        pop_q   <= ONE_HOT0 << sel_q;
                        push_q  <= '0;
                        pkt_q   <= D_pop[b][sel_q];
                        rr_q    <= rr_d;
                        state_q <= S_SEND;
                    end
                    S_SEND: begin
                        pop_q  <= '0;
                        push_q <= mask_d;
                        // Dropped packets leave the delivered data untouched.
                        if (|mask_d) begin
                            dpush_q <= pkt_q;
                        end
                        state_q <= S_IDLE;
                    end
                    default: begin
                        pop_q   <= '0;
                        push_q  <= '0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end

        assign pop[b]  = pop_q;
        assign push[b] = push_q;
        for (genvar d = 0; d < drvrs; d++) begin : g_lane
            assign D_push[b][d] = dpush_q;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Testbench for bs_gnrtr_n_rbtr: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a
// transaction-level model of the arbitration and delivery rules.
module tb_bs_gnrtr_n_rbtr;

    localparam int BITS = 2;
    localparam int DRV  = 4;
    localparam int PW   = 16;

    logic                              clk = 1'b0;
    logic                              reset;
    logic [BITS-1:0][DRV-1:0]          pndng;
    logic [BITS-1:0][DRV-1:0][PW-1:0]  D_pop;
    logic [BITS-1:0][DRV-1:0]          pop;
    logic [BITS-1:0][DRV-1:0]          push;
    logic [BITS-1:0][DRV-1:0][PW-1:0]  D_push;

    int n_chk  = 0;
    int n_pass = 0;

    bs_gnrtr_n_rbtr #(
        .bits     (BITS),
        .drvrs    (DRV),
        .pckg_sz  (PW),
        .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pndng (pndng),
        .D_pop (D_pop),
        .pop   (pop),
        .push  (push),
        .D_push(D_push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int               n_edge = 0;
    bit               m_valid = 1'b0;
    int               free_e[BITS];
    int               gedge[BITS];
    int               ptr[BITS];
    int               gsel[BITS];
    logic [PW-1:0]    gpkt[BITS];
    logic [DRV-1:0]   m_pop[BITS];
    logic [DRV-1:0]   m_push[BITS];
    logic [PW-1:0]    m_dp[BITS];

    function automatic logic [DRV-1:0] exp_mask(input logic [PW-1:0] pkt, input int src);
        logic [DRV-1:0] m;
        int dst;
        m   = '0;
        dst = int'(pkt[PW-1 -: 8]);
`ifdef BCAST_DELIVERY_EN
        if (dst == 255) begin
            for (int d = 0; d < DRV; d++) if (d != src) m[d] = 1'b1;
            return m;
        end
`endif
        if (dst < DRV) m[dst] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        n_edge = n_edge + 1;
        m_valid = 1'b1;
        for (int b = 0; b < BITS; b++) begin
            if (reset) begin
                ptr[b] = 0; gedge[b] = -100; free_e[b] = n_edge + 1;
                m_pop[b] = '0; m_push[b] = '0; m_dp[b] = '0;
            end else begin
                m_pop[b] = '0;
                m_push[b] = '0;
                if (n_edge == gedge[b] + 1) begin
                    m_pop[b][gsel[b]] = 1'b1;
                    gpkt[b] = D_pop[b][gsel[b]];
                end
                if (n_edge == gedge[b] + 2) begin
                    m_push[b] = exp_mask(gpkt[b], gsel[b]);
                    if (m_push[b] != '0) m_dp[b] = gpkt[b];
                end
                if (n_edge >= free_e[b] && pndng[b] != '0) begin
                    int pick;
                    pick = -1;
                    for (int k = 0; k < DRV; k++)
                        if (pick < 0 && pndng[b][(ptr[b] + k) % DRV]) pick = (ptr[b] + k) % DRV;
                    gsel[b]   = pick;
                    gedge[b]  = n_edge;
                    ptr[b]    = (pick + 1) % DRV;
                    free_e[b] = n_edge + 3;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int b = 0; b < BITS; b++) begin
                logic [DRV-1:0][PW-1:0] rep;
                for (int d = 0; d < DRV; d++) rep[d] = m_dp[b];
                chk($sformatf("cmp_pop_b%0d", b),   pop[b],    m_pop[b]);
                chk($sformatf("cmp_push_b%0d", b),  push[b],   m_push[b]);
                chk($sformatf("cmp_dpush_b%0d", b), D_push[b], rep);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int pidx[4];
    int pcyc[4];
    int np;

    initial begin
        reset = 1'b1;
        pndng = '1;
        D_pop = '0;
        for (int i = 0; i < 4; i++) begin pidx[i] = -1; pcyc[i] = -100; end

        // Reset held with every device requesting.
        repeat (2) begin
            cyc();
            chk("rst_pop",   pop,    '0);
            chk("rst_push",  push,   '0);
            chk("rst_dpush", D_push[0], '0);
        end
        reset = 1'b0;
        pndng = '0;

        // Unicast 1 -> 2.
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h02AB;
        cyc();
        chk("uni_nopop_yet", pop[0], 4'b0000);
        cyc();
        chk("uni_pop", pop[0], 4'b0010);
        chk("uni_model_pop", m_pop[0], 4'b0010);
        chk("uni_nopush_yet", push[0], 4'b0000);
        pndng[0][1] = 1'b0;
        cyc();
        chk("uni_push", push[0], 4'b0100);
        chk("uni_model_push", m_push[0], 4'b0100);
        chk("uni_pop_clear", pop[0], 4'b0000);
        chk("uni_data", D_push[0][2], 16'h02AB);
        cyc();
        chk("uni_push_clear", push[0], 4'b0000);
        chk("uni_data_hold", D_push[0][2], 16'h02AB);

        // Invalid destination from device 3.
        pndng[0][3] = 1'b1;
        D_pop[0][3] = 16'h0711;
        cyc();
        cyc();
        chk("inv_pop", pop[0], 4'b1000);
        pndng[0][3] = 1'b0;
        cyc();
        chk("inv_nopush", push[0], 4'b0000);
        chk("inv_data_hold", D_push[0][0], 16'h02AB);

        // Broadcast from device 0.
        pndng[0][0] = 1'b1;
        D_pop[0][0] = 16'hFF55;
        cyc();
        cyc();
        chk("bc_pop", pop[0], 4'b0001);
        pndng[0][0] = 1'b0;
        cyc();
`ifdef BCAST_DELIVERY_EN
        chk("bc_push", push[0], 4'b1110);
        chk("bc_data", D_push[0][1], 16'hFF55);
`else
        chk("bc_push", push[0], 4'b0000);
        chk("bc_data", D_push[0][1], 16'h02AB);
`endif
        cyc();

        // Fairness between devices 0 and 2, starting from reset.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        pndng[0][0] = 1'b1;
        pndng[0][2] = 1'b1;
        D_pop[0][0] = 16'h0133;
        D_pop[0][2] = 16'h0344;
        np = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (pop[0] != '0 && np < 4) begin
                for (int d = 0; d < DRV; d++) if (pop[0][d]) pidx[np] = d;
                pcyc[np] = i;
                np++;
            end
        end
        pndng[0] = '0;
        chk("fair_count", np, 4);
        chk("fair_idx0", pidx[0], 0);
        chk("fair_idx1", pidx[1], 2);
        chk("fair_idx2", pidx[2], 0);
        chk("fair_idx3", pidx[3], 2);
        for (int i = 1; i < 4; i++) chk($sformatf("fair_gap%0d", i), pcyc[i] - pcyc[i-1], 3);
        repeat (4) cyc();

        // Reset landing in the send cycle of a packet from device 1.
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h0122;
        cyc();
        cyc();
        chk("rsd_pop", pop[0], 4'b0010);
        reset = 1'b1;
        pndng[0] = '0;
        cyc();
        chk("rsd_nopush", push[0], 4'b0000);
        chk("rsd_nopop", pop[0], 4'b0000);
        reset = 1'b0;
        pndng[0][0] = 1'b1;
        pndng[0][2] = 1'b1;
        cyc();
        chk("rsd_nopush2", push[0], 4'b0000);
        cyc();
        chk("rsd_restart_dev0", pop[0], 4'b0001);
        pndng[0] = '0;
        repeat (3) cyc();

        // Randomized traffic on both buses.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int b = 0; b < BITS; b++) begin
                for (int d = 0; d < DRV; d++) begin
                    int r;
                    logic [7:0] dst;
                    pndng[b][d] = ($urandom_range(0, 2) == 0);
                    r = $urandom_range(0, 5);
                    if (r < 4)       dst = 8'(r);
                    else if (r == 4) dst = 8'hFF;
                    else             dst = 8'($urandom_range(0, 255));
                    D_pop[b][d] = {dst, 8'($urandom_range(0, 255))};
                end
            end
            cyc();
        end
        reset = 1'b0;
        pndng = '0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
